// File: rtl/fifo_queue_if.sv
// fifo_queue_if: handshake, threshold and status signals of one per-class FIFO
interface fifo_queue_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 2
);
  logic                 wr_enb;
  logic [DATA_BITS-1:0] data_in;
  logic                 rd_enb;
  logic [ADDR_BITS:0]   umbral_almost_full;
  logic [ADDR_BITS:0]   umbral_almost_empty;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic [ADDR_BITS:0]   count;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 fifo_error;
  modport master (
    output wr_enb, data_in, rd_enb, umbral_almost_full, umbral_almost_empty,
    input  data_out, valid_out, count, buf_empty, buf_full, almost_full, almost_empty, fifo_error
  );
  modport slave (
    input  wr_enb, data_in, rd_enb, umbral_almost_full, umbral_almost_empty,
    output data_out, valid_out, count, buf_empty, buf_full, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/fifo_queue.sv
// fifo_queue: single-clock FIFO with occupancy, threshold flags and sticky error
module fifo_queue #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 2
) (
  input logic         clk,
  input logic         rst,
  fifo_queue_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out, fifo_error;
  logic                 empty, full, rd_acc, wr_acc, err;
  always_comb begin
    empty  = count == '0;
    full   = count == (ADDR_BITS+1)'(DEPTH);
    rd_acc = bus.rd_enb && !empty;
    wr_acc = bus.wr_enb && (!full || rd_acc);
    err    = (bus.wr_enb && full && !bus.rd_enb) || (bus.rd_enb && empty);
  end
  always_ff @(posedge clk)
    if (wr_acc && !rst) mem[wr_ptr] <= bus.data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      valid_out  <= rd_acc;
      count      <= count + (ADDR_BITS+1)'(wr_acc) - (ADDR_BITS+1)'(rd_acc);
      fifo_error <= fifo_error || err;
    end
  end
  assign bus.data_out     = data_out;
  assign bus.valid_out    = valid_out;
  assign bus.count        = count;
  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.almost_full  = count >= bus.umbral_almost_full;
  assign bus.almost_empty = count <= bus.umbral_almost_empty;
  assign bus.fifo_error   = fifo_error;
endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue: directed plus random stimulus against a queue-based model with a decoupled read scoreboard
module tb_fifo_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fifo_queue_if #(.DATA_BITS(8), .ADDR_BITS(2)) bus ();
  fifo_queue #(.DATA_BITS(8), .ADDR_BITS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       model_err = 1'b0;
  logic [7:0] model_last = 8'h00;
  bit         done = 1'b0;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
    bit full, empty, racc, wacc;
    bus.wr_enb = w;
    bus.data_in = d;
    bus.rd_enb = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_err = 1'b0;
      model_last = 8'h00;
    end else begin
      full  = model_q.size() == 4;
      empty = model_q.size() == 0;
      racc  = r && !empty;
      wacc  = w && (!full || racc);
      if ((w && full && !r) || (r && empty)) model_err = 1'b1;
      if (racc) begin
        model_last = model_q.pop_front();
        exp_q.push_back(model_last);
      end
      if (wacc) model_q.push_back(d);
    end
    #1;
    chk("count", 32'(bus.count), 32'(model_q.size()));
    chk("buf_empty", 32'(bus.buf_empty), 32'(model_q.size() == 0));
    chk("buf_full", 32'(bus.buf_full), 32'(model_q.size() == 4));
    chk("almost_full", 32'(bus.almost_full), 32'(model_q.size() >= int'(bus.umbral_almost_full)));
    chk("almost_empty", 32'(bus.almost_empty), 32'(model_q.size() <= int'(bus.umbral_almost_empty)));
    chk("fifo_error", 32'(bus.fifo_error), 32'(model_err));
    chk("data_out_hold", 32'(bus.data_out), 32'(model_last));
    @(negedge clk);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (done) break;
      if (bus.valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got data %0h expected no word", bus.data_out);
        end else chk("read_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        chk("valid_out", 32'(bus.valid_out), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    bus.umbral_almost_full = 3'd3;
    bus.umbral_almost_empty = 3'd1;
    bus.wr_enb = 1'b0;
    bus.rd_enb = 1'b0;
    bus.data_in = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    step(1, 8'hEE, 1, 1);
    step(1, 8'hEE, 1, 1);
    chk("reset_valid", 32'(bus.valid_out), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0);
    chk("fill_full", 32'(bus.buf_full), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h20 + 8'(i), 0, 0);
    step(1, 8'h55, 1, 0);
    chk("full_simul_count", 32'(bus.count), 32'd4);
    chk("full_simul_noerr", 32'(bus.fifo_error), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    chk("last_is_55", 32'(bus.data_out), 32'h55);
    for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), 0, 0);
    step(1, 8'hCC, 0, 0);
    chk("overflow_err", 32'(bus.fifo_error), 32'd1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    chk("underflow_valid", 32'(bus.valid_out), 32'd0);
    chk("underflow_err", 32'(bus.fifo_error), 32'd1);
    step(1, 8'h77, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("err_sticky", 32'(bus.fifo_error), 32'd1);
    step(0, 8'h00, 0, 1);
    bus.umbral_almost_full = 3'd3;
    bus.umbral_almost_empty = 3'd1;
    for (int i = 0; i < 4; i++) step(1, 8'(i), 0, 0);
    bus.umbral_almost_full = 3'd0;
    #1 chk("af_zero_comb", 32'(bus.almost_full), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("af_zero_reset", 32'(bus.almost_full), 32'd1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.umbral_almost_full = 3'($urandom_range(0, 4));
        bus.umbral_almost_empty = 3'($urandom_range(0, 4));
      end
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 60) == 0);
    end
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    done = 1'b1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_queue.md
# fifo_queue

Synchronous single-clock FIFO that buffers one traffic class upstream of the round-robin arbiter; one instance exists per queue, and its `buf_empty` output feeds the arbiter's corresponding `buf_empty` bit. The FIFO accepts writes from the source side and pops on `rd_enb`, which the output mux drives when the arbiter selects this queue. It reports occupancy, programmable almost-full/almost-empty flags and sticky overflow/underflow errors.

## Interface
- `DATA_BITS`, 8, word width.
- `ADDR_BITS`, 2, pointer width; depth `DEPTH = 2**ADDR_BITS` (4 by default).
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_enb`  in  1  push `data_in` this cycle.
- `data_in`  in  DATA_BITS  write data.
- `rd_enb`  in  1  pop head word this cycle.
- `umbral_almost_full`  in  ADDR_BITS+1  almost-full threshold, 0..DEPTH.
- `umbral_almost_empty`  in  ADDR_BITS+1  almost-empty threshold, 0..DEPTH.
- `data_out`  out  DATA_BITS  registered popped word.
- `valid_out`  out  1  `data_out` holds a word popped the previous cycle.
- `count`  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- `buf_empty`  out  1  `count == 0`.
- `buf_full`  out  1  `count == DEPTH`.
- `almost_full`  out  1  `count >= umbral_almost_full`.
- `almost_empty`  out  1  `count <= umbral_almost_empty`.
- `fifo_error`  out  1  sticky: an overflow or underflow occurred since reset.

## Operation
- Storage: DEPTH×DATA_BITS register array, write pointer `wr_ptr`, read pointer `rd_ptr` (ADDR_BITS each, natural wrap DEPTH-1 → 0), occupancy counter `count` (ADDR_BITS+1).
- Accepted write: `wr_enb && (!buf_full || rd_acc)`. Stores `data_in` at `mem[wr_ptr]`; `wr_ptr` increments.
- Accepted read: `rd_acc = rd_enb && !buf_empty`. Registers `mem[rd_ptr]` into `data_out`; `rd_ptr` increments; sets `valid_out` = 1.
- When no read is accepted, `valid_out` = 0 and `data_out` holds its last value.
- `count` update: +1 for a write alone, -1 for a read alone, unchanged for both or neither.
- When full, a simultaneous read and write are both accepted. The read returns the old head; the write lands in the freed slot; `count` stays at DEPTH.
- When empty, a simultaneous read and write accept only the write, with no bypass. The read counts as an underflow; `count` goes 0 → 1.
- Overflow: `wr_enb && buf_full && !rd_enb`. Data is dropped, with no pointer or count change.
- Underflow: `rd_enb && buf_empty`. No pointer change; `valid_out` = 0.
- Either overflow or underflow sets `fifo_error` = 1, which holds until `rst`.
- Flags are purely combinational from the registered `count` and the threshold inputs. Thresholds may change at any time and take effect the same cycle. A threshold of 0 for almost_full makes `almost_full` always 1.

## Timing
- Reset (sync, next posedge with `rst` = 1) clears:
  - `wr_ptr`, `rd_ptr`, `count` to 0;
  - `data_out` to 0, `valid_out` to 0, `fifo_error` to 0.
- Reset results: `buf_empty` = 1, `buf_full` = 0, `almost_empty` = 1 (for any threshold), `almost_full` = (`umbral_almost_full` == 0).
- `rst` has priority over `wr_enb` and `rd_enb`. Reset mid-operation discards all contents; array contents need not be cleared.
- Write latency:
  - A word written at edge N is readable by `rd_enb` sampled at edge N+1.
  - `buf_empty` deasserts after edge N, in the same cycle the arbiter samples it.
- Read latency: `rd_enb` sampled at edge N → `data_out`/`valid_out` valid after edge N, for one cycle.
- Back-to-back reads stream one word per cycle in write order, across pointer wrap-around.
- Flags and `count` change only after a clock edge, with no combinational path from `wr_enb`/`rd_enb` to any output.

## Test plan
- Reset check: assert `rst` for 2 cycles with `wr_enb` = `rd_enb` = 1 → `count` = 0, `buf_empty` = 1, `valid_out` = 0, `fifo_error` = 0, `data_out` = 0.
- Fill and drain:
  - Write 0xA1, 0xA2, 0xA3, 0xA4 → `buf_full` = 1, `count` = 4.
  - Read 4 cycles → `data_out` = A1..A4 in order with `valid_out` = 1 each, then `buf_empty` = 1.
- Wrap-around: 3 writes, 2 reads, 3 writes (pointers wrap) → `count` = 4; the reads return the written values in order.
- Full simultaneous: when full, `wr_enb` = `rd_enb` = 1 with 0x55 → `data_out` = old head, `count` stays 4, no error. Then 4 reads → 0x55 comes out last.
- Errors:
  - Write when full with `rd_enb` = 0 → `count` stays 4 and `fifo_error` = 1.
  - After reset, read when empty → `valid_out` = 0 and `fifo_error` = 1.
  - `fifo_error` stays 1 until `rst`.
- Thresholds: with `umbral_almost_full` = 3 and `umbral_almost_empty` = 1, write 1..4 words → `almost_empty` is 1 at counts 0–1, and `almost_full` is 1 at counts 3–4.
